// File: rtl/sprite_fetch_sched.sv
// Per-pixel scheduler sharing one sprite ROM between P1/P2; optional collide output under SPRITE_COLLIDE_EN.
// Latency: pix_valid 4 cycles after accepted pix_req; throughput one request per 4 cycles.
// Backpressure: none; pix_req while pix_busy is dropped and sets sticky overrun.
module sprite_fetch_sched #(
  parameter int SPR_W       = 41,
  parameter int SPR_H       = 65,
  parameter int NUM_FRAMES  = 4,
  parameter int ANIM_DIV    = 8,
  parameter int ADDR_W      = 14,
  parameter int P1_PRIORITY = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_req,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        p1_x,
  input  logic [9:0]        p1_y,
  input  logic [9:0]        p2_x,
  input  logic [9:0]        p2_y,
  input  logic              p1_flip,
  input  logic              p2_flip,
  input  logic              p1_anim_en,
  input  logic              p2_anim_en,
  input  logic              frame_tick,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic              pix_busy,
  output logic              pix_valid,
  output logic              pixel_on,
  output logic [3:0]        lut_idx,
  output logic              overrun,
  output logic [1:0]        p1_frame,
  output logic [1:0]        p2_frame
`ifdef SPRITE_COLLIDE_EN
  ,
  output logic              collide
`endif
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [1:0] {IDLE, F1, F2, RES} state_t;

  state_t            state, state_nxt;
  logic              hit1_q, hit2_q;
  logic [ADDR_W-1:0] off1_q, off2_q;
  logic [3:0]        d1_q, d2, res_idx;
  logic [DIV_W-1:0]  p1_div, p2_div;

  // End coordinates carry an extra bit so sprites near 1023 do not wrap.
  function automatic logic hit_f(input logic [9:0] dx, input logic [9:0] dy,
                                 input logic [9:0] px, input logic [9:0] py);
    logic [10:0] x_end, y_end;
    x_end = {1'b0, px} + 11'(SPR_W);
    y_end = {1'b0, py} + 11'(SPR_H);
    return (dx >= px) && ({1'b0, dx} < x_end) && (dy >= py) && ({1'b0, dy} < y_end);
  endfunction

  function automatic logic [ADDR_W-1:0] off_f(input logic [9:0] dx, input logic [9:0] dy,
                                              input logic [9:0] px, input logic [9:0] py,
                                              input logic flip);
    logic [9:0] col, row;
    col = dx - px;
    row = dy - py;
    if (flip) col = 10'(SPR_W - 1) - col;
    return ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
  endfunction

  function automatic logic [ADDR_W-1:0] base_f(input logic [1:0] fr);
    return ADDR_W'(fr) * ADDR_W'(SPR_W * SPR_H);
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Frame base is added at issue time so a tick mid-request affects only later reads.
  always_comb begin
    state_nxt = state;
    rom_rd    = 1'b0;
    rom_addr  = '0;
    case (state)
      IDLE: if (pix_req) state_nxt = F1;
      F1: begin
        if (hit1_q) begin
          rom_rd   = 1'b1;
          rom_addr = base_f(p1_frame) + off1_q;
        end
        state_nxt = F2;
      end
      F2: begin
        if (hit2_q) begin
          rom_rd   = 1'b1;
          rom_addr = base_f(p2_frame) + off2_q;
        end
        state_nxt = RES;
      end
      RES:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pix_busy = (state != IDLE);

  always_comb begin
    d2      = hit2_q ? rom_data : 4'd0;
    res_idx = d2;
    if (d1_q != 4'd0 && d2 != 4'd0) res_idx = (P1_PRIORITY != 0) ? d1_q : d2;
    else if (d1_q != 4'd0)          res_idx = d1_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      off1_q    <= '0;
      off2_q    <= '0;
      d1_q      <= 4'd0;
      lut_idx   <= 4'd0;
      pixel_on  <= 1'b0;
      pix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      if (pix_req && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (pix_req) begin
          hit1_q <= hit_f(DrawX, DrawY, p1_x, p1_y);
          hit2_q <= hit_f(DrawX, DrawY, p2_x, p2_y);
          off1_q <= off_f(DrawX, DrawY, p1_x, p1_y, p1_flip);
          off2_q <= off_f(DrawX, DrawY, p2_x, p2_y, p2_flip);
        end
        F2: d1_q <= hit1_q ? rom_data : 4'd0;
        RES: begin
          lut_idx   <= res_idx;
          pixel_on  <= (res_idx != 4'd0);
          pix_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p1_div   <= '0;
      p1_frame <= 2'd0;
    end else if (frame_tick) begin
      if (!p1_anim_en) begin
        p1_div   <= '0;
        p1_frame <= 2'd0;
      end else if (p1_div == DIV_W'(ANIM_DIV - 1)) begin
        p1_div   <= '0;
        p1_frame <= (p1_frame == 2'(NUM_FRAMES - 1)) ? 2'd0 : p1_frame + 2'd1;
      end else begin
        p1_div   <= p1_div + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p2_div   <= '0;
      p2_frame <= 2'd0;
    end else if (frame_tick) begin
      if (!p2_anim_en) begin
        p2_div   <= '0;
        p2_frame <= 2'd0;
      end else if (p2_div == DIV_W'(ANIM_DIV - 1)) begin
        p2_div   <= '0;
        p2_frame <= (p2_frame == 2'(NUM_FRAMES - 1)) ? 2'd0 : p2_frame + 2'd1;
      end else begin
        p2_div   <= p2_div + DIV_W'(1);
      end
    end
  end

`ifdef SPRITE_COLLIDE_EN
  // A collision in RES outranks a simultaneous frame_tick clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                                          collide <= 1'b0;
    else if (state == RES && d1_q != 4'd0 && d2 != 4'd0)   collide <= 1'b1;
    else if (frame_tick)                                   collide <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Self-checking bench for sprite_fetch_sched against a tick-count / arithmetic reference model.
module tb_sprite_fetch_sched;
  localparam int SPR_W = 41, SPR_H = 65, NUM_FRAMES = 4, ANIM_DIV = 8, ADDR_W = 14;
  localparam int P1_PRIORITY = 1;

  logic Clk, Reset_n, pix_req, frame_tick;
  logic [9:0] DrawX, DrawY, p1_x, p1_y, p2_x, p2_y;
  logic p1_flip, p2_flip, p1_anim_en, p2_anim_en;
  logic rom_rd, pix_busy, pix_valid, pixel_on, overrun;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0] rom_data, lut_idx;
  logic [1:0] p1_frame, p2_frame;
`ifdef SPRITE_COLLIDE_EN
  logic collide;
`endif

  int checks = 0, failures = 0;
  logic [3:0] mem [0:16383];
  int rd_q[$];
  int cnt1 = 0, cnt2 = 0;
  bit exp_collide = 0;
  int obs_lat, obs_pulses, obs_busy;
  logic [3:0] obs_idx;
  logic obs_on;
  int exp_rd[$];
  int exp_idx;
  bit exp_both;

  sprite_fetch_sched dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_req(pix_req), .DrawX(DrawX), .DrawY(DrawY),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_flip(p1_flip), .p2_flip(p2_flip), .p1_anim_en(p1_anim_en), .p2_anim_en(p2_anim_en),
    .frame_tick(frame_tick), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_busy(pix_busy), .pix_valid(pix_valid), .pixel_on(pixel_on), .lut_idx(lut_idx),
    .overrun(overrun), .p1_frame(p1_frame), .p2_frame(p2_frame)
`ifdef SPRITE_COLLIDE_EN
    , .collide(collide)
`endif
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // ROM model: one-cycle read latency, garbage on the bus when not read.
  always @(posedge Clk) begin
    if (rom_rd) begin
      rom_data <= mem[rom_addr];
      rd_q.push_back(int'(rom_addr));
    end else begin
      rom_data <= 4'($urandom);
    end
  end

  function automatic int mframe(input int c);
    return (c / ANIM_DIV) % NUM_FRAMES;
  endfunction

  function automatic bit mhit(input int dx, input int dy, input int px, input int py);
    return dx >= px && dx < px + SPR_W && dy >= py && dy < py + SPR_H;
  endfunction

  function automatic int maddr(input int f, input int dx, input int dy, input int px, input int py, input bit flip);
    int col;
    col = dx - px;
    if (flip) col = SPR_W - 1 - col;
    return f * SPR_W * SPR_H + (dy - py) * SPR_W + col;
  endfunction

  task automatic tick_model();
    cnt1 = p1_anim_en ? cnt1 + 1 : 0;
    cnt2 = p2_anim_en ? cnt2 + 1 : 0;
    exp_collide = 0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk); frame_tick = 1; tick_model();
      @(negedge Clk); frame_tick = 0;
    end
  endtask

  // tick_at: cycle (0 = request cycle, 1..3) in which frame_tick is pulsed, -1 for none.
  task automatic run_pixel(input int dx, input int dy, input int tick_at);
    int na1, na2, f1, f2, d1, d2, a;
    na1 = p1_anim_en ? cnt1 + 1 : 0;
    na2 = p2_anim_en ? cnt2 + 1 : 0;
    f1 = (tick_at == 0) ? mframe(na1) : mframe(cnt1);
    f2 = (tick_at == 0 || tick_at == 1) ? mframe(na2) : mframe(cnt2);
    exp_rd.delete(); d1 = 0; d2 = 0;
    if (mhit(dx, dy, int'(p1_x), int'(p1_y))) begin
      a = maddr(f1, dx, dy, int'(p1_x), int'(p1_y), p1_flip);
      exp_rd.push_back(a); d1 = int'(mem[a]);
    end
    if (mhit(dx, dy, int'(p2_x), int'(p2_y))) begin
      a = maddr(f2, dx, dy, int'(p2_x), int'(p2_y), p2_flip);
      exp_rd.push_back(a); d2 = int'(mem[a]);
    end
    exp_both = (d1 != 0 && d2 != 0);
    exp_idx = exp_both ? ((P1_PRIORITY != 0) ? d1 : d2) : ((d1 != 0) ? d1 : d2);
    @(negedge Clk);
    rd_q.delete();
    DrawX = 10'(dx); DrawY = 10'(dy); pix_req = 1; frame_tick = (tick_at == 0);
    obs_lat = -1; obs_pulses = 0; obs_busy = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clk);
      if (pix_valid === 1'b1) begin obs_pulses++; if (obs_lat < 0) obs_lat = k; end
      if (pix_busy === 1'b1) obs_busy++;
      pix_req = 0; frame_tick = (k == tick_at);
    end
    frame_tick = 0;
    obs_idx = lut_idx; obs_on = pixel_on;
    if (tick_at >= 0) begin cnt1 = na1; cnt2 = na2; exp_collide = 0; end
    if (exp_both) exp_collide = 1;
  endtask

  task automatic test_reset();
    Reset_n = 0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({rom_rd, rom_addr, pix_busy, pix_valid, pixel_on, lut_idx, overrun, p1_frame, p2_frame} !== '0) begin
      failures++; $display("FAIL reset_outputs got rd=%b addr=%0d busy=%b vld=%b on=%b idx=%0d ovr=%b f1=%0d f2=%0d want all 0",
        rom_rd, rom_addr, pix_busy, pix_valid, pixel_on, lut_idx, overrun, p1_frame, p2_frame);
    end
`ifdef SPRITE_COLLIDE_EN
    checks++;
    if (collide !== 1'b0) begin failures++; $display("FAIL reset_collide got %b want 0", collide); end
`endif
    Reset_n = 1; cnt1 = 0; cnt2 = 0; exp_collide = 0;
    @(negedge Clk);
  endtask

  task automatic test_no_hit();
    p1_x = 300; p1_y = 300; p2_x = 300; p2_y = 300;
    run_pixel(100, 50, -1);
    checks++;
    if (obs_lat != 4 || obs_pulses != 1) begin failures++; $display("FAIL nohit_latency got lat=%0d pulses=%0d want 4/1", obs_lat, obs_pulses); end
    checks++;
    if (rd_q.size() != 0) begin failures++; $display("FAIL nohit_reads got %0d reads want 0", rd_q.size()); end
    checks++;
    if (obs_idx !== 4'd0 || obs_on !== 1'b0) begin failures++; $display("FAIL nohit_result got idx=%0d on=%b want 0/0", obs_idx, obs_on); end
    checks++;
    if (obs_busy != 3) begin failures++; $display("FAIL nohit_busy got %0d busy cycles want 3", obs_busy); end
  endtask

  task automatic test_p1_basic();
    p1_x = 100; p1_y = 40; p1_flip = 0; mem[87] = 4'h3;
    run_pixel(105, 42, -1);
    checks++;
    if (rd_q.size() != 1 || rd_q[0] != 87) begin failures++; $display("FAIL p1_addr got n=%0d a=%0d want 1 read at 87", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : -1); end
    checks++;
    if (obs_idx !== 4'd3 || obs_on !== 1'b1) begin failures++; $display("FAIL p1_result got idx=%0d on=%b want 3/1", obs_idx, obs_on); end
  endtask

  task automatic test_flip();
    p1_flip = 1; mem[117] = 4'h9;
    run_pixel(105, 42, -1);
    checks++;
    if (rd_q.size() != 1 || rd_q[0] != 117) begin failures++; $display("FAIL flip_addr got n=%0d a=%0d want 1 read at 117", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : -1); end
    checks++;
    if (obs_idx !== 4'd9) begin failures++; $display("FAIL flip_result got idx=%0d want 9", obs_idx); end
    p1_flip = 0;
  endtask

  task automatic test_overlap();
    p1_x = 100; p1_y = 40; p2_x = 100; p2_y = 40; p1_flip = 0; p2_flip = 1;
    mem[87] = 4'h5; mem[117] = 4'h7;
    run_pixel(105, 42, -1);
    checks++;
    if (rd_q.size() != 2 || rd_q[0] != 87 || rd_q[1] != 117) begin failures++; $display("FAIL overlap_reads got n=%0d want 87,117", rd_q.size()); end
    checks++;
    if (obs_idx !== 4'd5 || obs_on !== 1'b1) begin failures++; $display("FAIL overlap_result got idx=%0d on=%b want 5/1", obs_idx, obs_on); end
`ifdef SPRITE_COLLIDE_EN
    checks++;
    if (collide !== 1'b1) begin failures++; $display("FAIL overlap_collide got %b want 1", collide); end
    do_ticks(1);
    checks++;
    if (collide !== 1'b0) begin failures++; $display("FAIL collide_clear got %b want 0", collide); end
`endif
    p2_flip = 0;
  endtask

  task automatic test_anim();
    p1_anim_en = 0; p2_anim_en = 0;
    do_ticks(1);
    p1_anim_en = 1;
    do_ticks(8);
    checks++;
    if (int'(p1_frame) != mframe(cnt1) || p2_frame !== 2'd0) begin failures++; $display("FAIL anim_8 got f1=%0d f2=%0d want %0d/0", p1_frame, p2_frame, mframe(cnt1)); end
    do_ticks(23);
    checks++;
    if (int'(p1_frame) != mframe(cnt1)) begin failures++; $display("FAIL anim_31 got %0d want %0d", p1_frame, mframe(cnt1)); end
    do_ticks(1);
    checks++;
    if (int'(p1_frame) != mframe(cnt1)) begin failures++; $display("FAIL anim_wrap got %0d want %0d", p1_frame, mframe(cnt1)); end
    do_ticks(9);
    p1_anim_en = 0;
    do_ticks(1);
    checks++;
    if (p1_frame !== 2'd0 || int'(p1_frame) != mframe(cnt1)) begin failures++; $display("FAIL anim_disable got %0d want 0", p1_frame); end
  endtask

  task automatic test_random();
    int dx, dy, mode, tat;
    for (int it = 0; it < 60; it++) begin
      @(negedge Clk);
      p1_anim_en = 1'($urandom); p2_anim_en = 1'($urandom);
      do_ticks($urandom_range(0, 12));
      mode = $urandom_range(0, 2);
      dx = $urandom_range(0, 1023); dy = $urandom_range(0, 1023);
      if (mode == 2) begin
        dx = $urandom_range(985, 1023); dy = $urandom_range(985, 1023);
        p1_x = 10'($urandom_range(980, 1023)); p1_y = 10'($urandom_range(980, 1023));
        p2_x = 10'($urandom_range(980, 1023)); p2_y = 10'($urandom_range(980, 1023));
      end else if (mode == 1) begin
        p1_x = 10'((dx > 45) ? dx - $urandom_range(0, 45) : 0);
        p1_y = 10'((dy > 70) ? dy - $urandom_range(0, 70) : 0);
        p2_x = 10'((dx > 45) ? dx - $urandom_range(0, 45) : 0);
        p2_y = 10'((dy > 70) ? dy - $urandom_range(0, 70) : 0);
      end else begin
        p1_x = 10'($urandom); p1_y = 10'($urandom); p2_x = 10'($urandom); p2_y = 10'($urandom);
      end
      p1_flip = 1'($urandom); p2_flip = 1'($urandom);
      tat = int'($urandom_range(0, 4)) - 1;
      run_pixel(dx, dy, tat);
      checks++;
      if (obs_lat != 4 || obs_pulses != 1) begin failures++; $display("FAIL rnd%0d_latency got lat=%0d pulses=%0d want 4/1", it, obs_lat, obs_pulses); end
      checks++;
      if (rd_q != exp_rd) begin failures++; $display("FAIL rnd%0d_reads got %p want %p", it, rd_q, exp_rd); end
      checks++;
      if (int'(obs_idx) != exp_idx || obs_on !== (exp_idx != 0)) begin failures++; $display("FAIL rnd%0d_result got idx=%0d on=%b want %0d", it, obs_idx, obs_on, exp_idx); end
      checks++;
      if (int'(p1_frame) != mframe(cnt1) || int'(p2_frame) != mframe(cnt2)) begin
        failures++; $display("FAIL rnd%0d_frames got %0d/%0d want %0d/%0d", it, p1_frame, p2_frame, mframe(cnt1), mframe(cnt2));
      end
      checks++;
      if (overrun !== 1'b0) begin failures++; $display("FAIL rnd%0d_overrun got %b want 0", it, overrun); end
`ifdef SPRITE_COLLIDE_EN
      checks++;
      if (collide !== exp_collide) begin failures++; $display("FAIL rnd%0d_collide got %b want %b", it, collide, exp_collide); end
`endif
    end
    p1_anim_en = 0; p2_anim_en = 0;
  endtask

  task automatic test_overrun_reset();
    int pulses;
    p1_x = 300; p1_y = 300; p2_x = 300; p2_y = 300;
    @(negedge Clk); DrawX = 100; DrawY = 50; pix_req = 1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (pix_valid === 1'b1) pulses++;
      pix_req = (k == 2);
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL overrun_pulses got %0d want 1", pulses); end
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got %b want 1", overrun); end
    p1_x = 100; p1_y = 40;
    @(negedge Clk); DrawX = 105; DrawY = 42; pix_req = 1;
    @(negedge Clk); pix_req = 0;
    @(negedge Clk); Reset_n = 0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (pix_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL midreset_pulses got %0d want 0", pulses); end
    checks++;
    if ({rom_rd, rom_addr, pix_busy, pix_valid, pixel_on, lut_idx, overrun, p1_frame, p2_frame} !== '0) begin
      failures++; $display("FAIL midreset_outputs got busy=%b idx=%0d ovr=%b want all 0", pix_busy, lut_idx, overrun);
    end
    Reset_n = 1; cnt1 = 0; cnt2 = 0; exp_collide = 0;
    repeat (3) @(negedge Clk);
    checks++;
    if (pix_valid !== 1'b0 || pix_busy !== 1'b0) begin failures++; $display("FAIL postreset_idle got vld=%b busy=%b want 0/0", pix_valid, pix_busy); end
  endtask

  initial begin
    Reset_n = 0; pix_req = 0; frame_tick = 0; DrawX = 0; DrawY = 0;
    p1_x = 0; p1_y = 0; p2_x = 0; p2_y = 0;
    p1_flip = 0; p2_flip = 0; p1_anim_en = 0; p2_anim_en = 0;
    for (int i = 0; i < 16384; i++) mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
    test_reset();
    test_no_hit();
    test_p1_basic();
    test_flip();
    test_overlap();
    test_anim();
    test_random();
    test_overrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_sched.md
Name: sprite_fetch_sched

Overview:
- Schedules one shared sprite-pixel ROM between two fighter characters (P1, P2) for the per-pixel draw path.
- For each requested (DrawX, DrawY), it bounding-box tests both characters and issues up to two ROM reads back-to-back.
- Each read uses a per-player animation frame and facing flip; the two results are resolved into one palette index and a pixel_on flag.
- Sits between the VGA pixel request strobe and the colour mapper; the palette lookup stays downstream.

Parameters:
- SPR_W, 41, sprite width in pixels.
- SPR_H, 65, sprite height in pixels.
- NUM_FRAMES, 4, animation frames stored consecutively per sprite in ROM.
- ANIM_DIV, 8, frame_tick pulses per animation frame advance.
- ADDR_W, 14, ROM address width; must cover NUM_FRAMES*SPR_W*SPR_H.
- P1_PRIORITY, 1, 1 = P1 wins overlap, 0 = P2 wins.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- pix_req  in  1  one-cycle strobe: new pixel to resolve.
- DrawX  in  10  pixel column, sampled when pix_req is accepted.
- DrawY  in  10  pixel row, sampled when pix_req is accepted.
- p1_x, p1_y  in  10 each  P1 sprite top-left.
- p2_x, p2_y  in  10 each  P2 sprite top-left.
- p1_flip, p2_flip  in  1 each  1 = mirror horizontally.
- p1_anim_en, p2_anim_en  in  1 each  enable animation advance.
- frame_tick  in  1  one-cycle pulse per video frame (vsync edge).
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  4  palette index; valid the cycle after rom_rd.
- pix_busy  out  1  high in any state other than IDLE.
- pix_valid  out  1  one-cycle pulse; result valid.
- pixel_on  out  1  resolved pixel is opaque.
- lut_idx  out  4  resolved palette index (0 = transparent).
- overrun  out  1  sticky flag: pix_req arrived while busy.
- p1_frame, p2_frame  out  2 each  current animation frame index.

Behaviour:
- Reset (async, Reset_n=0):
  - All outputs 0; FSM in IDLE.
  - Frame indices and divider counters 0.
- FSM states and transitions:
  - IDLE -> F1 on pix_req. DrawX/DrawY are latched and both hit tests are registered.
  - F1: if P1 hit, rom_rd=1 with the P1 address; go to F2.
  - F2: capture P1 data if it was read, else d1=0. If P2 hit, rom_rd=1 with the P2 address; go to RES.
  - RES: capture P2 data if it was read, else d2=0. Resolve; pix_valid=1 for one cycle; return to IDLE.
- Latency: pix_valid is asserted exactly 4 cycles after the pix_req edge. Maximum throughput is one request per 4 cycles.
- Hit test: DrawX >= px && DrawX < px+SPR_W, and the same for Y against SPR_H. Compute the sums in 11 bits so a sprite near 1023 does not wrap.
- Address:
  - Base = frame*SPR_W*SPR_H; offset = (DrawY-py)*SPR_W + col.
  - col = DrawX-px when not flipped, SPR_W-1-(DrawX-px) when flipped.
- Resolve:
  - Only one of d1, d2 nonzero: output that one.
  - Both nonzero: the P1_PRIORITY winner.
  - Both zero: lut_idx=0, pixel_on=0.
  - pixel_on = (lut_idx != 0).
- lut_idx and pixel_on are registered and hold their value until the next RES.
- rom_rd is 0 for a non-hit player; no spurious reads are issued.
- pix_req outside IDLE: the request is ignored and overrun is set. overrun is cleared only by reset.
- Animation, per player, on frame_tick:
  - anim_en=0: divider and frame cleared to 0.
  - anim_en=1: divider increments. On reaching ANIM_DIV-1, divider -> 0 and frame -> (frame+1) mod NUM_FRAMES.
- A frame_tick coinciding with an in-flight fetch:
  - Frame indices update that cycle.
  - The address for a read already issued is unchanged.
  - A read issued later in the same request uses the new frame.
- Reset mid-fetch: return to IDLE immediately; no pix_valid is produced.

Optional Feature:
- Macro SPRITE_COLLIDE_EN.
- Defined:
  - Adds output collide (1 bit), set in RES when d1 != 0 and d2 != 0.
  - collide is sticky until the next frame_tick, which clears it; a set in the same cycle as frame_tick wins.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then pix_req at DrawX=100, DrawY=50 with both sprites at (300,300) -> no rom_rd; pix_valid 4 cycles later; pixel_on=0, lut_idx=0.
- P1 at (100,40), frame 0, no flip; pix_req at (105,42), rom_data=4'h3 -> rom_addr=2*41+5=87; lut_idx=3, pixel_on=1.
- Same request with p1_flip=1 -> rom_addr=2*41+35=117.
- P1 and P2 both at (100,40), rom_data 5 then 7 -> lut_idx=5 with P1_PRIORITY=1; collide=1 under SPRITE_COLLIDE_EN, cleared by the next frame_tick.
- p1_anim_en=1, 8 frame_ticks -> p1_frame=1; after 32 ticks it wraps to 0; deasserting anim_en then one tick -> 0.
- pix_req again 2 cycles after an accepted request -> second request dropped, overrun=1, a single pix_valid; assert Reset_n=0 during F2 -> pix_valid never pulses, all outputs 0.
